// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - host byte stream to instruction-memory loader
// Packs big-endian bytes into words, writes them from address 0 and holds the CPU until the halt sentinel lands.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic                  in_ready,
   input  logic                  start,
   output logic                  wr_en,
   output logic [31:0]           wr_addr,
   output logic [31:0]           wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam logic [31:0]           SENTINEL  = 32'hFFFF_FFFF;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

   typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [31:0]           asm_reg;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  is_sentinel;

   assign is_sentinel = (asm_reg == SENTINEL);
   assign wr_data     = asm_reg;
   assign wr_addr     = {{(30-ADDR_WIDTH){1'b0}}, word_addr, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      wr_en     = 1'b0;
      case (state)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            wr_en = 1'b1;
            if (is_sentinel || word_addr == LAST_ADDR) state_nxt = S_DONE;
            else                                       state_nxt = S_LOAD;
         end
         S_DONE: begin
            if (start) state_nxt = S_LOAD;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_reg    <= '0;
         byte_cnt   <= '0;
         word_addr  <= '0;
         word_count <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid) begin
                  asm_reg  <= {asm_reg[23:0], in_byte};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            S_WRITE: begin
               word_count <= word_count + COUNT_ONE;
               // Address saturates at the top word so an overflowing image never wraps onto word 0.
               if (word_addr != LAST_ADDR) word_addr <= word_addr + ADDR_ONE;
               if (is_sentinel) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else if (word_addr == LAST_ADDR) begin
                  done  <= 1'b1;
                  error <= 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  asm_reg    <= '0;
                  byte_cnt   <= '0;
                  word_addr  <= '0;
                  word_count <= '0;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
